// File: rtl/pipeline_acc_pkg.sv
// Shared types, default widths and parameter legality checks for the
// packet accumulation pipeline.
package pipeline_acc_pkg;

    typedef enum logic {
        OP_SUM = 1'b0,
        OP_XOR = 1'b1
    } op_e;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_N_PORTS   = 4;
    localparam int DEF_PKT_WORDS = 16;
    localparam int DEF_LAT_A     = 2;
    localparam int DEF_LAT_B     = 3;
    localparam int DEF_SUM_W_B   = 64;

    // A packet must be a whole number of beats.
    function automatic bit pkt_words_ok(int pkt_words, int n_ports);
        return (n_ports > 0) && (pkt_words >= n_ports) && (pkt_words % n_ports == 0);
    endfunction

    // Every result channel needs at least one register stage.
    function automatic bit lat_ok(int lat);
        return lat >= 1;
    endfunction

    // The wide channel must hold a full-precision sum plus the +1.
    function automatic bit sum_w_ok(int sum_w_b, int data_w, int pkt_words);
        return sum_w_b >= data_w + $clog2(pkt_words) + 1;
    endfunction

endpackage

// File: rtl/pipeline_acc_if.sv
// Beat input and result output bundle of pipeline_acc.
interface pipeline_acc_if
    import pipeline_acc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_PORTS = DEF_N_PORTS,
    parameter int SUM_W_B = DEF_SUM_W_B
);
    logic [N_PORTS*DATA_W-1:0] in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      op_sel;
    logic                      pkt_done;
    logic [DATA_W-1:0]         out_a;
    logic                      out_a_valid;
    logic [SUM_W_B-1:0]        out_b;
    logic                      out_b_valid;
    logic [15:0]               pkt_count;

    modport master (
        output in_data, in_valid, in_last, op_sel,
        input  pkt_done, out_a, out_a_valid, out_b, out_b_valid, pkt_count
    );

    modport slave (
        input  in_data, in_valid, in_last, op_sel,
        output pkt_done, out_a, out_a_valid, out_b, out_b_valid, pkt_count
    );
endinterface

// File: rtl/pipeline_delay.sv
// Fixed-latency {valid, data} delay line. Data advances only alongside a
// valid, so the output data holds its last delivered value between pulses.
module pipeline_delay #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [LAT-1:0] vld_q;
    logic [W-1:0]   dat_q [LAT];

    // Shift valids every cycle; move each data stage only with its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) dat_q[k] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) dat_q[0] <= in_data;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_data  = dat_q[LAT-1];
endmodule

// File: rtl/pipeline_acc.sv
// Packet gatherer and reducer: collects N_PORTS words per accepted beat into a
// PKT_WORDS-word snapshot, reduces it by SUM or XOR, and delivers a truncated
// result (channel A) and a wide result + 1 (channel B) on independent latencies.
module pipeline_acc
    import pipeline_acc_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_PORTS   = DEF_N_PORTS,
    parameter int PKT_WORDS = DEF_PKT_WORDS,
    parameter int LAT_A     = DEF_LAT_A,
    parameter int LAT_B     = DEF_LAT_B,
    parameter int SUM_W_B   = DEF_SUM_W_B
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_acc_if.slave bus
);
    localparam int BEATS = PKT_WORDS / N_PORTS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!pkt_words_ok(PKT_WORDS, N_PORTS)) begin : g_bad_pkt_words
        $error("PKT_WORDS must be a non-zero multiple of N_PORTS");
    end
    if (!lat_ok(LAT_A) || !lat_ok(LAT_B)) begin : g_bad_latency
        $error("LAT_A and LAT_B must be at least 1");
    end
    if (!sum_w_ok(SUM_W_B, DATA_W, PKT_WORDS)) begin : g_bad_sum_w
        $error("SUM_W_B too narrow for a full-precision packet sum plus one");
    end

    logic [CNT_W-1:0]   beat_cnt;
    logic               final_beat;
    op_e                op_q;
    op_e                pkt_op;
    op_e                snap_op;
    logic [DATA_W-1:0]  buf_q  [PKT_WORDS];
    logic [DATA_W-1:0]  snap_d [PKT_WORDS];
    logic [DATA_W-1:0]  snap_q [PKT_WORDS];
    logic [SUM_W_B-1:0] result;
    logic               pkt_done_q;
    logic [15:0]        pkt_count_q;

    assign final_beat = bus.in_valid && (bus.in_last || (int'(beat_cnt) == BEATS - 1));
    // The op of a packet is whatever op_sel shows on its first beat.
    assign pkt_op     = (beat_cnt == '0) ? op_e'(bus.op_sel) : op_q;

    // Assemble the completed packet: stored beats, the final beat, zero padding.
    always_comb begin
        for (int i = 0; i < PKT_WORDS; i++) begin
            if (i / N_PORTS < int'(beat_cnt))
                snap_d[i] = buf_q[i];
            else if (i / N_PORTS == int'(beat_cnt))
                snap_d[i] = bus.in_data[(i % N_PORTS) * DATA_W +: DATA_W];
            else
                snap_d[i] = '0;
        end
    end

    // Control state: beat position, op latch, completion pulse, packet count.
    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (rst) begin
            beat_cnt    <= '0;
            op_q        <= OP_SUM;
            snap_op     <= OP_SUM;
            pkt_done_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            pkt_done_q <= final_beat;
            if (bus.in_valid) begin
                if (beat_cnt == '0) op_q <= op_e'(bus.op_sel);
                if (final_beat) begin
                    beat_cnt    <= '0;
                    snap_op     <= pkt_op;
                    pkt_count_q <= pkt_count_q + 16'd1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Word storage for the partial packet and the completed snapshot.
    always_ff @(posedge clk) begin
        // NOTE: data-only arrays take no reset; beat_cnt and pkt_done gate their use.
        if (bus.in_valid) begin
            for (int p = 0; p < N_PORTS; p++)
                buf_q[int'(beat_cnt) * N_PORTS + p] <= bus.in_data[p * DATA_W +: DATA_W];
        end
        if (final_beat) snap_q <= snap_d;
    end

    // Reduce the snapshot by the op captured with it.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves result latched.
        result = '0;
        for (int i = 0; i < PKT_WORDS; i++) begin
            if (snap_op == OP_XOR) result = result ^ SUM_W_B'(snap_q[i]);
            else                   result = result + SUM_W_B'(snap_q[i]);
        end
    end

    pipeline_delay #(.W(DATA_W), .LAT(LAT_A)) u_delay_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pkt_done_q),
        .in_data   (result[DATA_W-1:0]),
        .out_valid (bus.out_a_valid),
        .out_data  (bus.out_a)
    );

    pipeline_delay #(.W(SUM_W_B), .LAT(LAT_B)) u_delay_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pkt_done_q),
        .in_data   (result + SUM_W_B'(1)),
        .out_valid (bus.out_b_valid),
        .out_data  (bus.out_b)
    );

    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_pipeline_acc.sv
// Bench for pipeline_acc: a default 16-word instance and a one-beat-per-packet
// instance (LAT_A=1, LAT_B=5), checked each cycle against a packet-level model.
module tb_pipeline_acc;
    import pipeline_acc_pkg::*;

    typedef struct {
        int          t_done;
        int          t_a;
        int          t_b;
        logic [31:0] a;
        logic [63:0] b;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int          n_beats;
        bit          use_last;
        bit          op;
        bit          flip;
        int          gap [4];
        logic [31:0] w   [16];
        logic [31:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_q = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        qd [2][$];
    exp_t        qa [2][$];
    exp_t        qb [2][$];
    logic [31:0] last_a [2];
    logic [63:0] last_b [2];
    logic [15:0] cnt_model [2];
    int          lat_a [2] = '{2, 1};
    int          lat_b [2] = '{3, 5};
    vec_t        tbl [8];

    pipeline_acc_if #(.DATA_W(32), .N_PORTS(4), .SUM_W_B(64)) bus0 ();
    pipeline_acc_if #(.DATA_W(32), .N_PORTS(4), .SUM_W_B(64)) bus1 ();

    pipeline_acc #(.DATA_W(32), .N_PORTS(4), .PKT_WORDS(16), .LAT_A(2), .LAT_B(3), .SUM_W_B(64))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipeline_acc #(.DATA_W(32), .N_PORTS(4), .PKT_WORDS(4), .LAT_A(1), .LAT_B(5), .SUM_W_B(64))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(int d, string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s: actual=0x%0h expected=0x%0h (cycle %0d)", d, name, act, exp, cyc);
        end
    endtask

    // Packet-level reference: plain sum or xor of the words actually sent.
    function automatic logic [63:0] ref_reduce(logic [31:0] w [16], int n, bit op);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = op ? (r ^ {32'd0, w[i]}) : (r + {32'd0, w[i]});
        return r;
    endfunction

    // Per-cycle comparison of one instance against the expected event queues.
    task automatic mon(int d, logic done, logic va, logic [31:0] a, logic vb, logic [63:0] b,
                       logic [15:0] cnt);
        bit e;
        if (rst_q) begin
            while (qd[d].size() > 0 && qd[d][$].t_done >= cyc) void'(qd[d].pop_back());
            while (qa[d].size() > 0 && qa[d][$].t_a >= cyc) void'(qa[d].pop_back());
            while (qb[d].size() > 0 && qb[d][$].t_b >= cyc) void'(qb[d].pop_back());
            last_a[d] = '0;
            last_b[d] = '0;
            check(d, "reset pkt_done", done, 0);
            check(d, "reset out_a_valid", va, 0);
            check(d, "reset out_b_valid", vb, 0);
            check(d, "reset out_a", a, 0);
            check(d, "reset out_b", b, 0);
            check(d, "reset pkt_count", cnt, 0);
            return;
        end
        e = qd[d].size() > 0 && qd[d][0].t_done == cyc;
        check(d, "pkt_done", done, e);
        if (e) begin
            check(d, "pkt_count", cnt, qd[d][0].cnt);
            void'(qd[d].pop_front());
        end
        e = qa[d].size() > 0 && qa[d][0].t_a == cyc;
        check(d, "out_a_valid", va, e);
        if (e) begin
            check(d, "out_a", a, qa[d][0].a);
            last_a[d] = qa[d][0].a;
            void'(qa[d].pop_front());
        end else begin
            check(d, "out_a hold", a, last_a[d]);
        end
        e = qb[d].size() > 0 && qb[d][0].t_b == cyc;
        check(d, "out_b_valid", vb, e);
        if (e) begin
            check(d, "out_b", b, qb[d][0].b);
            last_b[d] = qb[d][0].b;
            void'(qb[d].pop_front());
        end else begin
            check(d, "out_b hold", b, last_b[d]);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.pkt_done, bus0.out_a_valid, bus0.out_a, bus0.out_b_valid, bus0.out_b, bus0.pkt_count);
        mon(1, bus1.pkt_done, bus1.out_a_valid, bus1.out_a, bus1.out_b_valid, bus1.out_b, bus1.pkt_count);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, logic v, logic [127:0] data, logic last, logic op);
        if (d == 0) begin
            bus0.in_valid = v; bus0.in_data = data; bus0.in_last = last; bus0.op_sel = op;
        end else begin
            bus1.in_valid = v; bus1.in_data = data; bus1.in_last = last; bus1.op_sel = op;
        end
    endtask

    // Idle cycles carry junk on every qualified input.
    task automatic idle(int d);
        drive(d, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
    endtask

    task automatic send_pkt(int d, vec_t v, bit use_model);
        logic [127:0] data;
        logic [63:0]  r;
        exp_t         e;
        for (int b = 0; b < v.n_beats; b++) begin
            for (int g = 0; g < v.gap[b]; g++) begin
                idle(d);
                step();
            end
            for (int p = 0; p < 4; p++) data[p*32 +: 32] = v.w[b*4 + p];
            drive(d, 1'b1, data, v.use_last && (b == v.n_beats - 1),
                  (b == 0) ? v.op : (v.flip ? ~v.op : 1'($urandom)));
            if (b == v.n_beats - 1) begin
                cnt_model[d] = cnt_model[d] + 16'd1;
                if (use_model) begin
                    r   = ref_reduce(v.w, v.n_beats * 4, v.op);
                    e.a = r[31:0];
                    e.b = r + 64'd1;
                end else begin
                    e.a = v.exp_a;
                    e.b = v.exp_b;
                end
                e.t_done = cyc + 1;
                e.t_a    = cyc + 1 + lat_a[d];
                e.t_b    = cyc + 1 + lat_b[d];
                e.cnt    = cnt_model[d];
                qd[d].push_back(e);
                qa[d].push_back(e);
                qb[d].push_back(e);
            end
            step();
        end
        idle(d);
    endtask

    // kind: 0 = word b+p in beat b, 1 = all ones, 2 = {1,2,3,4}, 3 = every word 1
    function automatic vec_t mk(int n, bit last, bit op, bit flip, int g0, int g1, int g2, int g3,
                                int kind, logic [31:0] ea, logic [63:0] eb);
        vec_t v;
        v.n_beats = n; v.use_last = last; v.op = op; v.flip = flip;
        v.gap = '{g0, g1, g2, g3};
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       v.w[i] = 32'(i / 4 + i % 4);
                1:       v.w[i] = 32'hFFFF_FFFF;
                2:       v.w[i] = (i < 4) ? 32'(i + 1) : 32'hDEAD_BEEF;
                default: v.w[i] = 32'd1;
            endcase
        end
        v.exp_a = ea;
        v.exp_b = eb;
        return v;
    endfunction

    task automatic drain(int n);
        idle(0);
        idle(1);
        repeat (n) step();
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(4, 0, OP_SUM, 0, 0, 0, 0, 0, 0, 32'd48, 64'd49);
        tbl[1] = mk(4, 0, OP_SUM, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF0, 64'h0000_000F_FFFF_FFF1);
        tbl[2] = mk(4, 0, OP_XOR, 0, 0, 0, 0, 0, 1, 32'd0, 64'd1);
        tbl[3] = mk(1, 1, OP_SUM, 0, 0, 0, 0, 0, 2, 32'd10, 64'd11);
        tbl[4] = mk(4, 0, OP_SUM, 0, 0, 0, 0, 0, 0, 32'd48, 64'd49);
        tbl[5] = mk(4, 0, OP_SUM, 1, 0, 2, 1, 0, 0, 32'd48, 64'd49);
        tbl[6] = mk(4, 1, OP_SUM, 0, 0, 0, 0, 0, 3, 32'd16, 64'd17);
        tbl[7] = mk(4, 0, OP_XOR, 1, 1, 1, 1, 1, 0, 32'd0, 64'd1);

        cnt_model = '{16'd0, 16'd0};
        last_a    = '{32'd0, 32'd0};
        last_b    = '{64'd0, 64'd0};
        idle(0);
        idle(1);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Directed packets from the table, back to back.
        for (int i = 0; i < 8; i++) send_pkt(0, tbl[i], 0);
        drain(8);

        // Abort a packet after three beats; the next full packet counts as #1.
        for (int b = 0; b < 3; b++) begin
            drive(0, 1'b1, {32'(b + 3), 32'(b + 2), 32'(b + 1), 32'(b)}, 1'b0, 1'b1);
            step();
        end
        idle(0);
        rst = 1'b1;
        cnt_model = '{16'd0, 16'd0};
        step();
        rst = 1'b0;
        step();
        send_pkt(0, tbl[0], 0);
        drain(8);

        // Reset during T+1 cancels both pending result pulses.
        send_pkt(0, tbl[0], 0);
        step();
        rst = 1'b1;
        cnt_model = '{16'd0, 16'd0};
        step();
        rst = 1'b0;
        drain(8);

        // Random packets: random lengths, gaps, ops and data.
        for (int i = 0; i < 20; i++) begin
            v.n_beats  = $urandom_range(1, 4);
            v.use_last = (v.n_beats < 4) ? 1'b1 : 1'($urandom);
            v.op       = 1'($urandom);
            v.flip     = 1'($urandom);
            for (int b = 0; b < 4; b++) v.gap[b] = $urandom_range(0, 2);
            for (int k = 0; k < 16; k++) v.w[k] = $urandom;
            send_pkt(0, v, 1);
        end
        drain(8);

        // One-beat packets on every cycle through the second instance.
        for (int i = 0; i < 10; i++) begin
            v.n_beats  = 1;
            v.use_last = 1'($urandom);
            v.op       = 1'($urandom);
            v.flip     = 1'b0;
            v.gap      = '{0, 0, 0, 0};
            for (int k = 0; k < 16; k++) v.w[k] = $urandom;
            send_pkt(1, v, 1);
        end
        drain(10);

        for (int d = 0; d < 2; d++) begin
            check(d, "unfired pkt_done", qd[d].size(), 0);
            check(d, "unfired out_a", qa[d].size(), 0);
            check(d, "unfired out_b", qb[d].size(), 0);
        end
        check(0, "final pkt_count", bus0.pkt_count, cnt_model[0]);
        check(1, "final pkt_count", bus1.pkt_count, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_acc.md
Name: pipeline_acc

Overview:
Parametrised successor to the fixed 4-port / 16-word packet summing pipeline.
- Gathers N_PORTS words per accepted beat into a PKT_WORDS-word packet.
- Reduces each completed packet by SUM or XOR, selected per packet.
- Emits two result channels, each with its own parametrised latency: A is the narrow truncated result, B is the wide result + 1.
- Adds valid-gated input with gaps, early packet termination with zero padding, and a completed-packet counter.

Parameters:
DATA_W, 32, width of each input word and of out_a
N_PORTS, 4, words accepted per beat
PKT_WORDS, 16, words per packet; must be a multiple of N_PORTS (elaboration error otherwise)
LAT_A, 2, cycles from pkt_done to out_a_valid; must be >=1
LAT_B, 3, cycles from pkt_done to out_b_valid; must be >=1
SUM_W_B, 64, out_b width; must be >= DATA_W + clog2(PKT_WORDS) + 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_data  in  N_PORTS*DATA_W  beat words; word p is bits [p*DATA_W +: DATA_W] and goes to packet slot beat*N_PORTS+p
in_valid  in  1  beat accepted on a rising edge when high (no backpressure)
in_last  in  1  qualified by in_valid; this beat ends the packet early
op_sel  in  1  0 = SUM, 1 = XOR; sampled on the first beat of each packet only
pkt_done  out  1  one-cycle pulse: snapshot holds a complete packet
out_a  out  DATA_W  reduction result, truncated to DATA_W
out_a_valid  out  1  out_a qualifier
out_b  out  SUM_W_B  zero-extended full-precision reduction + 1
out_b_valid  out  1  out_b qualifier
pkt_count  out  16  number of completed packets, wraps

Behaviour:
Reset values:
- When rst is high at an edge: beat counter 0, pkt_done 0, all valids 0, out_a 0, out_b 0, pkt_count 0.
- Any partial packet is discarded and all delay-line contents are flushed; no stale valid may appear after reset.

Beat handling:
- BEATS = PKT_WORDS/N_PORTS.
- The beat counter advances only on in_valid; gaps of any length hold the counter and the partial packet.

Packet completion:
- A packet completes at the edge accepting beat BEATS-1, or any beat with in_last=1.
- At that edge, the full packet, including the final beat's words, is written into a snapshot register.
- Unfilled slots are zeroed (short packet).
- The beat counter returns to 0, and pkt_done is high for exactly the next cycle (cycle T).
- in_last on the final beat is redundant and behaves as a normal completion.

Reduction:
- Combinational over the snapshot during T: SUM (full-precision) or XOR, per the op latched at beat 0.

Output timing:
- out_a_valid is high in cycle T+LAT_A, and out_a is stable with it.
- out_b_valid is high in cycle T+LAT_B.
- Valid/data travel through matched shift delay lines; there are no stalls.
- Each valid is a single-cycle pulse per packet. out_a/out_b hold their last value between pulses.

Back-to-back packets:
- With BEATS=1, pkt_done may be high every cycle; the pipeline sustains one result per cycle per channel.
- A new packet may start accepting beats in cycle T; the snapshot is not disturbed until its next completion.

Other rules:
- pkt_count increments in cycle T (registered with pkt_done) and wraps 0xFFFF->0.
- Arithmetic is unsigned. out_a = result[DATA_W-1:0]. out_b = {zero-extended result}+1 modulo 2^SUM_W_B.
- Reset asserted while packets are in flight: all pending valids are cancelled.

Decomposition:
pipeline_pkg:
- op_e enum {OP_SUM=0, OP_XOR=1}.
- Parameter legality checks as functions.
- Default width constants.

Sub-module pipeline_delay #(W, LAT):
- Synchronous-reset shift register of {valid, data}, with valid cleared on rst.
- Instantiated once for channel A and once for channel B.

Test Plan:
- Defaults, SUM, in_valid continuous. Beat b carries {b, b+1, b+2, b+3} for b=0..3 (packet words 0..6 pattern) -> pkt_done 1 cycle after beat 3; out_a=48 at T+2; out_b=49 at T+3; pkt_count=1.
- All 16 words 0xFFFFFFFF, SUM -> out_a=0xFFFFFFF0, out_b=0x0000000F_FFFFFFF1. Repeat with op_sel=1 (XOR) -> out_a=0, out_b=1.
- Short packet: one beat {1,2,3,4} with in_last=1 -> pkt_done next cycle; out_a=10; out_b=11. Next full packet is unaffected by the padding.
- in_valid toggling 1,0,0,1,0,1,1 across one packet, with op_sel flipped mid-packet -> same result as the continuous case; op taken from beat 0 only.
- Reset pulse after beat 2, then a full packet -> no valid from the aborted packet; pkt_count restarts at 1. Also: rst during T+1 -> neither out_a_valid nor out_b_valid fires.
- N_PORTS=4, PKT_WORDS=4, LAT_A=1, LAT_B=5, ten back-to-back packets -> ten consecutive out_a_valid pulses and ten out_b_valid pulses, in order and matching a reference model; pkt_count=10.
